// File: rtl/display_mode_sequencer_pkg.sv
// display_mode_sequencer_pkg: page/state types and decoder select codes for the mode sequencer.
package display_mode_sequencer_pkg;
    typedef enum logic [1:0] {PG_TIME, PG_SEC, PG_DAY, PG_DATE} page_t;
    typedef enum logic {SQ_AUTO, SQ_MANUAL} seq_state_t;
    localparam logic [2:0] SEL_TIME = 3'b000;
    localparam logic [2:0] SEL_SEC  = 3'b001;
    localparam logic [2:0] SEL_DAY  = 3'b010;
    localparam logic [2:0] SEL_DATE = 3'b100;
    function automatic logic [2:0] sel_of(input page_t p);
        return p == PG_SEC ? SEL_SEC : p == PG_DAY ? SEL_DAY : p == PG_DATE ? SEL_DATE : SEL_TIME;
    endfunction
endpackage

// File: rtl/display_mode_sequencer_key_debounce.sv
// display_mode_sequencer_key_debounce: synchronises and debounces an active-low key,
// emitting a one-clk strobe on each accepted press.
module display_mode_sequencer_key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic s1, s2, lvl;
    logic [CW-1:0] cnt;
    assign pressed = ~lvl;
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            lvl   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                lvl   <= s2;
                cnt   <= '0;
                press <= ~s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/display_mode_sequencer.sv
// display_mode_sequencer: rotates the HEX decoder page on 1 Hz ticks, with a debounced
// key that steps pages manually and suspends rotation for a hold period.
module display_mode_sequencer
    import display_mode_sequencer_pkg::*;
#(
    parameter int DWELL_TIME  = 10,
    parameter int DWELL_OTHER = 3,
    parameter int HOLD_S      = 30,
    parameter int DEB_CYCLES  = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       key_n,
    input  logic       auto_en,
    input  logic       sync_ok,
    output logic [2:0] sel,
    output logic [1:0] page,
    output logic       manual
);
    seq_state_t state;
    page_t      pg;
    logic [7:0] dwell_cnt, hold_cnt;
    logic       pressed, press, key_evt;
    page_t      pg_inc;
    logic [7:0] dwell_lim;
    display_mode_sequencer_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_n),
        .pressed(pressed),
        .press  (press)
    );
    // press is only ever raised together with the accepted pressed level
    assign key_evt   = press & pressed;
    assign pg_inc    = page_t'(pg + 2'd1);
    assign dwell_lim = pg == PG_TIME ? 8'(DWELL_TIME - 1) : 8'(DWELL_OTHER - 1);
    assign page      = pg;
    always_ff @(posedge clk) begin
        if (reset || !sync_ok) begin
            state     <= SQ_AUTO;
            pg        <= PG_TIME;
            sel       <= SEL_TIME;
            manual    <= 1'b0;
            dwell_cnt <= '0;
            hold_cnt  <= '0;
        end else if (key_evt) begin
            state     <= SQ_MANUAL;
            manual    <= 1'b1;
            pg        <= pg_inc;
            sel       <= sel_of(pg_inc);
            hold_cnt  <= '0;
            if (state == SQ_AUTO) dwell_cnt <= '0;
        end else if (tick_1hz && state == SQ_MANUAL) begin
            if (hold_cnt == 8'(HOLD_S - 1)) begin
                state     <= SQ_AUTO;
                manual    <= 1'b0;
                pg        <= PG_TIME;
                sel       <= SEL_TIME;
                dwell_cnt <= '0;
                hold_cnt  <= '0;
            end else begin
                hold_cnt <= hold_cnt + 8'd1;
            end
        end else if (tick_1hz && auto_en) begin
            if (dwell_cnt == dwell_lim) begin
                pg        <= pg_inc;
                sel       <= sel_of(pg_inc);
                dwell_cnt <= '0;
            end else begin
                dwell_cnt <= dwell_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_display_mode_sequencer.sv
// tb_display_mode_sequencer: directed scenarios with hand-computed page/sel/manual expectations.
module tb_display_mode_sequencer;
    logic clk = 0, reset = 1, tick_1hz = 0, key_n = 1, auto_en = 1, sync_ok = 1;
    logic [2:0] sel;
    logic [1:0] page;
    logic manual;
    int checks = 0, failures = 0;

    display_mode_sequencer #(.DWELL_TIME(4), .DWELL_OTHER(2), .HOLD_S(5), .DEB_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .key_n(key_n),
        .auto_en(auto_en), .sync_ok(sync_ok), .sel(sel), .page(page), .manual(manual)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1; tick_1hz = 0; key_n = 1; auto_en = 1; sync_ok = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1;
            @(negedge clk);
            tick_1hz = 0;
            @(negedge clk);
        end
    endtask

    task automatic press_key();
        key_n = 0;
        repeat (8) @(negedge clk);
        key_n = 1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({page, sel, manual} !== {2'd0, 3'b000, 1'b0}) begin
            failures++; $display("FAIL reset page=%0d sel=%b manual=%b exp 0/000/0", page, sel, manual);
        end
    endtask

    task automatic test_rotation();
        do_reset();
        ticks(3);
        checks++;
        if ({page, sel} !== {2'd0, 3'b000}) begin
            failures++; $display("FAIL rot_3ticks page=%0d sel=%b exp 0/000", page, sel);
        end
        ticks(1);
        checks++;
        if ({page, sel} !== {2'd1, 3'b001}) begin
            failures++; $display("FAIL rot_4ticks page=%0d sel=%b exp 1/001", page, sel);
        end
        ticks(2);
        checks++;
        if ({page, sel} !== {2'd2, 3'b010}) begin
            failures++; $display("FAIL rot_6ticks page=%0d sel=%b exp 2/010", page, sel);
        end
        ticks(2);
        checks++;
        if ({page, sel} !== {2'd3, 3'b100}) begin
            failures++; $display("FAIL rot_8ticks page=%0d sel=%b exp 3/100", page, sel);
        end
        ticks(2);
        checks++;
        if ({page, sel, manual} !== {2'd0, 3'b000, 1'b0}) begin
            failures++; $display("FAIL rot_wrap page=%0d sel=%b manual=%b exp 0/000/0", page, sel, manual);
        end
    endtask

    task automatic test_press_and_glitch();
        do_reset();
        press_key();
        checks++;
        if ({page, sel, manual} !== {2'd1, 3'b001, 1'b1}) begin
            failures++; $display("FAIL press page=%0d sel=%b manual=%b exp 1/001/1", page, sel, manual);
        end
        ticks(4);
        checks++;
        if ({page, manual} !== {2'd1, 1'b1}) begin
            failures++; $display("FAIL hold_4ticks page=%0d manual=%b exp 1/1", page, manual);
        end
        ticks(1);
        checks++;
        if ({page, sel, manual} !== {2'd0, 3'b000, 1'b0}) begin
            failures++; $display("FAIL hold_expire page=%0d sel=%b manual=%b exp 0/000/0", page, sel, manual);
        end
        key_n = 0;
        repeat (3) @(negedge clk);
        key_n = 1;
        repeat (12) @(negedge clk);
        checks++;
        if ({page, manual} !== {2'd0, 1'b0}) begin
            failures++; $display("FAIL glitch page=%0d manual=%b exp 0/0", page, manual);
        end
    endtask

    task automatic test_press_tick_collision();
        do_reset();
        key_n = 0;
        repeat (6) @(negedge clk);
        tick_1hz = 1;
        @(negedge clk);
        tick_1hz = 0;
        repeat (3) @(negedge clk);
        key_n = 1;
        repeat (10) @(negedge clk);
        checks++;
        if ({page, manual} !== {2'd1, 1'b1}) begin
            failures++; $display("FAIL collide page=%0d manual=%b exp 1/1", page, manual);
        end
        ticks(4);
        checks++;
        if ({page, manual} !== {2'd1, 1'b1}) begin
            failures++; $display("FAIL collide_hold page=%0d manual=%b exp 1/1", page, manual);
        end
        ticks(1);
        checks++;
        if ({page, manual} !== {2'd0, 1'b0}) begin
            failures++; $display("FAIL collide_exit page=%0d manual=%b exp 0/0", page, manual);
        end
    endtask

    task automatic test_manual_repress();
        do_reset();
        press_key();
        ticks(3);
        press_key();
        checks++;
        if ({page, sel, manual} !== {2'd2, 3'b010, 1'b1}) begin
            failures++; $display("FAIL repress page=%0d sel=%b manual=%b exp 2/010/1", page, sel, manual);
        end
        ticks(4);
        checks++;
        if ({page, manual} !== {2'd2, 1'b1}) begin
            failures++; $display("FAIL repress_hold page=%0d manual=%b exp 2/1", page, manual);
        end
        ticks(1);
        checks++;
        if ({page, manual} !== {2'd0, 1'b0}) begin
            failures++; $display("FAIL repress_exit page=%0d manual=%b exp 0/0", page, manual);
        end
    endtask

    task automatic test_auto_disable();
        do_reset();
        ticks(2);
        auto_en = 0;
        ticks(20);
        checks++;
        if ({page, manual} !== {2'd0, 1'b0}) begin
            failures++; $display("FAIL frozen page=%0d manual=%b exp 0/0", page, manual);
        end
        auto_en = 1;
        ticks(1);
        checks++;
        if (page !== 2'd0) begin
            failures++; $display("FAIL dwell_held_early page=%0d exp 0", page);
        end
        ticks(1);
        checks++;
        if (page !== 2'd1) begin
            failures++; $display("FAIL dwell_held page=%0d exp 1", page);
        end
        auto_en = 0;
        press_key();
        checks++;
        if ({page, manual} !== {2'd2, 1'b1}) begin
            failures++; $display("FAIL noauto_press page=%0d manual=%b exp 2/1", page, manual);
        end
        ticks(5);
        checks++;
        if ({page, manual} !== {2'd0, 1'b0}) begin
            failures++; $display("FAIL noauto_exit page=%0d manual=%b exp 0/0", page, manual);
        end
        auto_en = 1;
    endtask

    task automatic test_sync_loss();
        do_reset();
        ticks(6);
        sync_ok = 0;
        @(negedge clk);
        checks++;
        if ({page, sel, manual} !== {2'd0, 3'b000, 1'b0}) begin
            failures++; $display("FAIL sync_loss page=%0d sel=%b manual=%b exp 0/000/0", page, sel, manual);
        end
        press_key();
        checks++;
        if ({page, manual} !== {2'd0, 1'b0}) begin
            failures++; $display("FAIL sync_press page=%0d manual=%b exp 0/0", page, manual);
        end
        sync_ok = 1;
        ticks(3);
        checks++;
        if (page !== 2'd0) begin
            failures++; $display("FAIL sync_resume3 page=%0d exp 0", page);
        end
        ticks(1);
        checks++;
        if (page !== 2'd1) begin
            failures++; $display("FAIL sync_resume4 page=%0d exp 1", page);
        end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        press_key();
        ticks(2);
        key_n = 0;
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        checks++;
        if ({page, sel, manual} !== {2'd0, 3'b000, 1'b0}) begin
            failures++; $display("FAIL reset_mid page=%0d sel=%b manual=%b exp 0/000/0", page, sel, manual);
        end
        key_n = 1;
        reset = 0;
        repeat (12) @(negedge clk);
        checks++;
        if ({page, manual} !== {2'd0, 1'b0}) begin
            failures++; $display("FAIL reset_deb page=%0d manual=%b exp 0/0", page, manual);
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_press_and_glitch();
        test_press_tick_collision();
        test_manual_repress();
        test_auto_disable();
        test_sync_loss();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
